// File: rtl/addsub_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | addsub_pkg                                                                |
// | Shared op encodings, FSM states and flag bundle for the acc sequencer.    |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
package addsub_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_flag_calc.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | addsub_flag_calc                                                          |
// | Combinational commit value and status flags from the adder's operands.    |
// | Optional saturation on signed overflow: ADDSUB_ACC_SAT_EN.                |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
module addsub_flag_calc
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] value,
  output flags_t           flags
);

  localparam int c_msb = WIDTH - 1;

  logic [WIDTH-1:0] w_beff;
  logic             w_ovf;

  // Subtraction feeds the adder the inverted operand, so overflow is judged on that.
  assign w_beff = b ^ {WIDTH{sel}};
  assign w_ovf  = (a[c_msb] == w_beff[c_msb]) && (s[c_msb] != a[c_msb]);

  always_comb begin
    value       = '0;
    flags.carry = 1'b0;
    flags.ovf   = 1'b0;
    if (is_arith(op)) begin
      value       = s;
      flags.carry = cout;
      flags.ovf   = w_ovf;
`ifdef ADDSUB_ACC_SAT_EN
      // Both inputs positive means the overflow went positive.
      if (w_ovf) begin
        value        = '0;
        value[c_msb] = a[c_msb];
        for (int i = 0; i < c_msb; i++) begin
          value[i] = ~a[c_msb];
        end
      end
`endif
    end else if (op == OP_LOAD) begin
      value = b;
    end
    flags.zero = (value == '0);
    flags.neg  = value[c_msb];
  end

endmodule
`default_nettype wire

// File: rtl/addsub_acc_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | addsub_acc_sequencer                                                      |
// | Accumulator controller around an external ripple adder/subtractor.        |
// | Optional saturation: define ADDSUB_ACC_SAT_EN.                            |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
module addsub_acc_sequencer
  import addsub_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sel,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] acc_q,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_zero,
  output logic             flag_neg
);

  localparam logic [3:0] c_cnt_load = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_op;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sel;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  flags_t           r_flags;

  logic [WIDTH-1:0] w_value;
  flags_t           w_flags;

  addsub_flag_calc #(
    .WIDTH (WIDTH)
  ) u_flag_calc (
    .a     (r_a),
    .b     (r_b),
    .sel   (r_sel),
    .s     (add_s),
    .cout  (add_cout),
    .op    (r_op),
    .value (w_value),
    .flags (w_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= OP_LOAD;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_op        <= cmd_op;
            r_a         <= r_acc;
            r_b         <= cmd_operand;
            r_sel       <= (cmd_op == OP_SUB);
            r_cnt       <= c_cnt_load;
            r_cmd_ready <= 1'b0;
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_acc       <= w_value;
            r_flags     <= w_flags;
            r_sel       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign add_a      = r_a;
  assign add_b      = r_b;
  assign add_sel    = r_sel;
  assign acc_q      = r_acc;
  assign flag_carry = r_flags.carry;
  assign flag_ovf   = r_flags.ovf;
  assign flag_zero  = r_flags.zero;
  assign flag_neg   = r_flags.neg;

endmodule
`default_nettype wire

// File: tb/tb_addsub_acc_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_addsub_acc_sequencer                                                   |
// | Directed + random checks of the sequencer against an arithmetic model.    |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
module tb_addsub_acc_sequencer;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;

  localparam logic [1:0] T_LOAD  = 2'b00;
  localparam logic [1:0] T_ADD   = 2'b01;
  localparam logic [1:0] T_SUB   = 2'b10;
  localparam logic [1:0] T_CLEAR = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_operand = '0;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sel;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] acc_q;
  logic             flag_carry, flag_ovf, flag_zero, flag_neg;

  // Stand-in for the external ripple adder/subtractor: a + ~b + 1 when subtracting.
  logic [WIDTH:0] adder_sum;
  assign adder_sum = add_sel ? ({1'b0, add_a} + {1'b0, ~add_b} + 5'd1)
                             : ({1'b0, add_a} + {1'b0, add_b});
  assign {add_cout, add_s} = adder_sum;

  addsub_acc_sequencer #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_sel     (add_sel),
    .add_s       (add_s),
    .add_cout    (add_cout),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .acc_q       (acc_q),
    .flag_carry  (flag_carry),
    .flag_ovf    (flag_ovf),
    .flag_zero   (flag_zero),
    .flag_neg    (flag_neg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int m_acc = 0;
  int m_c = 0, m_v = 0, m_z = 0, m_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_flags();
    return {28'd0, flag_carry, flag_ovf, flag_zero, flag_neg};
  endfunction

  function automatic logic [31:0] exp_flags();
    return {28'd0, m_c[0], m_v[0], m_z[0], m_n[0]};
  endfunction

  function automatic int to_signed(input int v);
    return (v > 7) ? v - 16 : v;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_c = 0; m_v = 0; m_z = 0; m_n = 0;
  endtask

  // Plain integer arithmetic on the 4-bit accumulator.
  task automatic model_step(input logic [1:0] op, input int b);
    int sr, r;
    sr = 0;
    r  = 0;
    m_c = 0;
    m_v = 0;
    case (op)
      T_LOAD:  r = b;
      T_CLEAR: r = 0;
      T_ADD: begin
        r   = (m_acc + b) % 16;
        m_c = (m_acc + b > 15) ? 1 : 0;
        sr  = to_signed(m_acc) + to_signed(b);
        m_v = (sr > 7 || sr < -8) ? 1 : 0;
      end
      default: begin
        r   = (m_acc - b + 16) % 16;
        m_c = (m_acc >= b) ? 1 : 0;
        sr  = to_signed(m_acc) - to_signed(b);
        m_v = (sr > 7 || sr < -8) ? 1 : 0;
      end
    endcase
`ifdef ADDSUB_ACC_SAT_EN
    if (m_v != 0) r = (sr > 7) ? 7 : 8;
`endif
    m_acc = r;
    m_z = (r == 0) ? 1 : 0;
    m_n = (r >= 8) ? 1 : 0;
  endtask

  // Called at a negedge; returns at the negedge right after the response handshake.
  task automatic run_op(input logic [1:0] op, input logic [3:0] b, input int hold,
                        input bit busy_cmd, input bit rnd_ready);
    int w;
    int prev_acc;
    cmd_op      = op;
    cmd_operand = b;
    cmd_valid   = 1'b1;
    if (rnd_ready) rsp_ready = 1'($urandom);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      return;
    end
    prev_acc = m_acc;
    @(negedge clk);
    model_step(op, int'(b));
    if (busy_cmd) begin
      cmd_op      = 2'($urandom);
      cmd_operand = 4'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    for (int k = 0; k < SETTLE; k++) begin
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("exec_sel", 32'(add_sel), 32'(op == T_SUB));
      chk("exec_a", 32'(add_a), 32'(prev_acc));
      chk("exec_b", 32'(add_b), 32'(b));
      if (rnd_ready) rsp_ready = 1'($urandom);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("acc", 32'(acc_q), 32'(m_acc));
    chk("flags", dut_flags(), exp_flags());
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_acc", 32'(acc_q), 32'(m_acc));
      chk("hold_flags", dut_flags(), exp_flags());
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    chk("rst_acc", 32'(acc_q), 32'd0);
    chk("rst_flags", dut_flags(), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_adder_in", {23'd0, add_a, add_b, add_sel}, 32'd0);

    run_op(T_LOAD, 4'h5, 0, 1'b0, 1'b0);
    run_op(T_ADD,  4'h3, 0, 1'b0, 1'b0);
    run_op(T_LOAD, 4'h3, 0, 1'b0, 1'b0);
    run_op(T_SUB,  4'h3, 0, 1'b0, 1'b0);
    run_op(T_LOAD, 4'h2, 0, 1'b0, 1'b0);
    run_op(T_SUB,  4'h5, 5, 1'b1, 1'b0);
    run_op(T_CLEAR, 4'h9, 1, 1'b0, 1'b0);
    run_op(T_LOAD, 4'h5, 0, 1'b0, 1'b0);

    // Reset arrives while the ADD is executing.
    cmd_op = T_ADD; cmd_operand = 4'h4; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_acc", 32'(acc_q), 32'd0);
    chk("midrst_flags", dut_flags(), 32'd0);
    chk("midrst_adder_in", {23'd0, add_a, add_b, add_sel}, 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_op(T_LOAD, 4'h9, 0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      run_op(2'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
